// File: rtl/lab2_proc_fwd_pkg.sv
// Shared types for the forwarding register file: tracker entry layout and
// address-width helper.
package lab2_proc_fwd_pkg;

  // Entry payload fields are sized for the widest supported configuration.
  // Narrower instances zero-extend into them, so the upper bits stay zero.
  localparam int FWD_MAX_NBITS = 128;
  localparam int FWD_MAX_AW    = 16;

  typedef struct packed {
    logic                     val;
    logic                     wen;
    logic [FWD_MAX_AW-1:0]    waddr;
    logic [FWD_MAX_NBITS-1:0] data;
    logic                     rdy;
  } fwd_entry_t;

  function automatic int fwd_aw(input int nregs);
    return (nregs > 1) ? $clog2(nregs) : 1;
  endfunction

endpackage

// File: rtl/lab2_proc_fwd_entry.sv
// One in-flight tracker stage: loads from the stage behind it, holds while
// stalled (picking up a late result), and is cleared by squash.
module lab2_proc_fwd_entry
  import lab2_proc_fwd_pkg::*;
#(
  parameter int p_nbits = 32
)(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     en,
  input  logic                     squash,
  input  fwd_entry_t               load_ent,
  input  logic                     produce_val,
  input  logic [p_nbits-1:0]       produce_data,
  output fwd_entry_t               ent,
  output logic                     eff_avail,
  output logic [FWD_MAX_NBITS-1:0] eff_data
);

  // Squash beats load; a held entry latches its result once and keeps it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ent <= '0;
    end else if (squash) begin
      ent <= '0;
    end else if (en) begin
      ent <= load_ent;
    end else if (produce_val && !ent.rdy) begin
      ent.data <= FWD_MAX_NBITS'(produce_data);
      ent.rdy  <= 1'b1;
    end
  end

  // Stored result wins; otherwise the value the stage is producing right now.
  always_comb begin
    eff_avail = ent.rdy | produce_val;
    eff_data  = ent.rdy ? ent.data : FWD_MAX_NBITS'(produce_data);
  end

endmodule

// File: rtl/lab2_proc_fwd_regfile.sv
// Register file with in-flight destination tracking, forwarding and per-port
// stall. Stage 0 is the youngest (X); the last stage retires into the array.
module lab2_proc_fwd_regfile
  import lab2_proc_fwd_pkg::*;
#(
  parameter  int p_nbits   = 32,
  parameter  int p_nregs   = 32,
  parameter  int p_nrd     = 2,
  parameter  int p_nstages = 3,
  localparam int AW        = fwd_aw(p_nregs)
)(
  input  logic                              clk,
  input  logic                              reset,
  input  logic [p_nrd-1:0][AW-1:0]          rd_addr,
  output logic [p_nrd-1:0][p_nbits-1:0]     rd_data,
  output logic [p_nrd-1:0]                  rd_stall,
  input  logic                              iss_val,
  input  logic                              iss_wen,
  input  logic [AW-1:0]                     iss_waddr,
  input  logic [p_nstages-1:0]              stage_en,
  input  logic [p_nstages-1:0]              stage_squash,
  input  logic [p_nstages-1:0]              produce_val,
  input  logic [p_nstages-1:0][p_nbits-1:0] produce_data,
  output logic                              wb_val,
  output logic [AW-1:0]                     wb_addr,
  output logic [p_nbits-1:0]                wb_data
);

  localparam int LAST = p_nstages - 1;

  fwd_entry_t               ent      [p_nstages];
  fwd_entry_t               load_ent [p_nstages];
  logic [p_nstages-1:0]     eff_avail;
  logic [FWD_MAX_NBITS-1:0] eff_data [p_nstages];
  logic [FWD_MAX_NBITS-1:0] fwd_full [p_nrd];
  logic [p_nrd-1:0]         hit;
  logic [p_nbits-1:0]       regs     [p_nregs];
  logic                     unused_bits;

  for (genvar s = 0; s < p_nstages; s++) begin : g_stage
    lab2_proc_fwd_entry #(.p_nbits(p_nbits)) u_entry (
      .clk          (clk),
      .reset        (reset),
      .en           (stage_en[s]),
      .squash       (stage_squash[s]),
      .load_ent     (load_ent[s]),
      .produce_val  (produce_val[s]),
      .produce_data (produce_data[s]),
      .ent          (ent[s]),
      .eff_avail    (eff_avail[s]),
      .eff_data     (eff_data[s])
    );
  end

  // Next value offered to each stage: the issuing instruction for stage 0,
  // the advancing older entry (or a bubble if it is not moving) for the rest.
  always_comb begin
    for (int s = 0; s < p_nstages; s++) load_ent[s] = '0;
    load_ent[0].val   = iss_val;
    load_ent[0].wen   = iss_wen;
    load_ent[0].waddr = FWD_MAX_AW'(iss_waddr);
    for (int s = 1; s < p_nstages; s++) begin
      if (stage_en[s-1]) begin
        load_ent[s].val   = ent[s-1].val;
        load_ent[s].wen   = ent[s-1].wen;
        load_ent[s].waddr = ent[s-1].waddr;
        load_ent[s].rdy   = eff_avail[s-1];
        load_ent[s].data  = eff_avail[s-1] ? eff_data[s-1] : '0;
      end
    end
  end

  // Youngest matching writer wins; a match without a result stalls the port.
  // A match also covers the retiring entry, so the array is never read stale.
  always_comb begin
    for (int p = 0; p < p_nrd; p++) begin
      fwd_full[p] = '0;
      rd_stall[p] = 1'b0;
      hit[p]      = 1'b0;
      if (rd_addr[p] != '0) begin
        for (int s = 0; s < p_nstages; s++) begin
          if (!hit[p] && ent[s].val && ent[s].wen &&
              ent[s].waddr == FWD_MAX_AW'(rd_addr[p])) begin
            hit[p] = 1'b1;
            if (eff_avail[s]) fwd_full[p] = eff_data[s];
            else              rd_stall[p] = 1'b1;
          end
        end
        if (!hit[p]) fwd_full[p] = FWD_MAX_NBITS'(regs[rd_addr[p]]);
      end
      rd_data[p] = fwd_full[p][p_nbits-1:0];
    end
  end

  // A squashed or result-less oldest entry never reaches the array.
  assign wb_val  = ent[LAST].val & ent[LAST].wen & (ent[LAST].waddr != '0) &
                   stage_en[LAST] & ~stage_squash[LAST] & eff_avail[LAST];
  assign wb_addr = ent[LAST].waddr[AW-1:0];
  assign wb_data = eff_data[LAST][p_nbits-1:0];

  // Architectural array; register 0 is excluded by wb_val and stays zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < p_nregs; r++) regs[r] <= '0;
    end else if (wb_val) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Payload bits above p_nbits are constant zero; fold them so they are consumed.
  always_comb begin
    unused_bits = 1'b0;
    for (int s = 0; s < p_nstages; s++)
      unused_bits = unused_bits ^ (^ent[s].data) ^ ent[s].rdy;
    for (int p = 0; p < p_nrd; p++)
      unused_bits = unused_bits ^ (^fwd_full[p][FWD_MAX_NBITS-1:p_nbits]);
  end

endmodule

// File: tb/tb_lab2_proc_fwd_regfile.sv
// Bench for the forwarding register file: directed pipeline scenarios, a
// writeback scoreboard fed at issue time, and combinational read checks.
module tb_lab2_proc_fwd_regfile;

  localparam int NB  = 32;
  localparam int NR  = 32;
  localparam int NRD = 2;
  localparam int NS  = 3;
  localparam int AW  = 5;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NRD-1:0][AW-1:0]  rd_addr;
  logic [NRD-1:0][NB-1:0]  rd_data;
  logic [NRD-1:0]          rd_stall;
  logic                    iss_val;
  logic                    iss_wen;
  logic [AW-1:0]           iss_waddr;
  logic [NS-1:0]           stage_en;
  logic [NS-1:0]           stage_squash;
  logic [NS-1:0]           produce_val;
  logic [NS-1:0][NB-1:0]   produce_data;
  logic                    wb_val;
  logic [AW-1:0]           wb_addr;
  logic [NB-1:0]           wb_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [AW-1:0] addr;
    logic [NB-1:0] data;
  } wb_t;
  wb_t wb_q [$];

  lab2_proc_fwd_regfile #(
    .p_nbits   (NB),
    .p_nregs   (NR),
    .p_nrd     (NRD),
    .p_nstages (NS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .rd_stall     (rd_stall),
    .iss_val      (iss_val),
    .iss_wen      (iss_wen),
    .iss_waddr    (iss_waddr),
    .stage_en     (stage_en),
    .stage_squash (stage_squash),
    .produce_val  (produce_val),
    .produce_data (produce_data),
    .wb_val       (wb_val),
    .wb_addr      (wb_addr),
    .wb_data      (wb_data)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int count_val();
    return int'(dut.ent[0].val) + int'(dut.ent[1].val) + int'(dut.ent[2].val);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    iss_val      = 1'b0;
    iss_wen      = 1'b0;
    iss_waddr    = '0;
    stage_en     = '1;
    stage_squash = '0;
    produce_val  = '0;
    produce_data = '0;
  endtask

  task automatic issue(input logic [AW-1:0] a, input logic [NB-1:0] d, input logic retires);
    wb_t w;
    iss_val   = 1'b1;
    iss_wen   = 1'b1;
    iss_waddr = a;
    if (retires) begin
      w.addr = a;
      w.data = d;
      wb_q.push_back(w);
    end
  endtask

  task automatic produce(input int s, input logic [NB-1:0] d);
    produce_val[s]  = 1'b1;
    produce_data[s] = d;
  endtask

  task automatic read_chk(input string tag, input int p, input logic [AW-1:0] a,
                          input logic [NB-1:0] exp_d, input logic exp_s);
    rd_addr[p] = a;
    #1;
    check_val({tag, "_data"}, 64'(rd_data[p]), 64'(exp_d));
    check_val({tag, "_stall"}, 64'(rd_stall[p]), 64'(exp_s));
  endtask

  // Every architectural write must match the oldest outstanding issue.
  always @(negedge clk) begin
    if (reset && wb_val) begin
      check_val("wb_expected", 64'(wb_q.size() != 0), 64'd1);
      if (wb_q.size() != 0) begin
        wb_t w;
        w = wb_q.pop_front();
        check_val("wb_addr", 64'(wb_addr), 64'(w.addr));
        check_val("wb_data", 64'(wb_data), 64'(w.data));
      end
    end
  end

  // The oldest stage must never advance a writer that has no result.
  always @(negedge clk) begin
    if (reset)
      assert (!(dut.ent[NS-1].val && dut.ent[NS-1].wen && stage_en[NS-1] &&
                !dut.eff_avail[NS-1]))
        else $error("oldest stage advancing without a result");
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    rd_addr = '0;
    rd_addr[0] = 5'd5;
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    check_val("rst_wb_val", 64'(wb_val), 64'd0);
    check_val("rst_stall", 64'(rd_stall), 64'd0);
    check_val("rst_data", 64'(rd_data[0]), 64'd0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;

    // back-to-back dependency
    idle(); issue(5'd5, 32'd7, 1'b1); step();
    idle(); produce(0, 32'd7); read_chk("b2b_x", 0, 5'd5, 32'd7, 1'b0); step();
    idle(); read_chk("b2b_m", 1, 5'd5, 32'd7, 1'b0); step();
    idle(); read_chk("b2b_w", 0, 5'd5, 32'd7, 1'b0);
    check_val("b2b_wb_val", 64'(wb_val), 64'd1); step();
    idle(); read_chk("b2b_arch", 0, 5'd5, 32'd7, 1'b0);
    check_val("b2b_wb_idle", 64'(wb_val), 64'd0); step();

    // load-use: result only appears in stage 1
    idle(); issue(5'd6, 32'h55, 1'b1); step();
    idle(); read_chk("lu_stall", 0, 5'd6, 32'd0, 1'b1); step();
    idle(); produce(1, 32'h55); read_chk("lu_fwd", 0, 5'd6, 32'h55, 1'b0); step();
    idle(); step();
    idle(); read_chk("lu_arch", 1, 5'd6, 32'h55, 1'b0); step();

    // priority between two writers, then squash the younger one
    idle(); issue(5'd3, 32'hA, 1'b1); step();
    idle(); issue(5'd3, 32'hB, 1'b0); produce(0, 32'hA); step();
    idle(); produce(0, 32'hB);
    read_chk("pri_young", 0, 5'd3, 32'hB, 1'b0);
    read_chk("pri_young_p1", 1, 5'd3, 32'hB, 1'b0);
    stage_en = '0; stage_squash = 3'b001; step();
    idle(); read_chk("pri_squash", 0, 5'd3, 32'hA, 1'b0); step();
    idle(); step();
    idle(); read_chk("pri_arch", 0, 5'd3, 32'hA, 1'b0); step();

    // writes to x0 are tracked but never visible or retired
    idle(); issue(5'd0, 32'hFF, 1'b0); step();
    idle(); produce(0, 32'hFF);
    read_chk("x0_x", 0, 5'd0, 32'd0, 1'b0);
    read_chk("x0_x_p1", 1, 5'd0, 32'd0, 1'b0); step();
    idle(); read_chk("x0_m", 0, 5'd0, 32'd0, 1'b0); step();
    idle(); read_chk("x0_w", 1, 5'd0, 32'd0, 1'b0);
    check_val("x0_wb_val", 64'(wb_val), 64'd0); step();

    // stage 0 held for one cycle: stage 1 takes a bubble
    idle(); issue(5'd7, 32'h77, 1'b1); step();
    idle(); produce(0, 32'h77); stage_en = 3'b110; step();
    idle(); read_chk("bub_hold", 0, 5'd7, 32'h77, 1'b0);
    check_val("bub_count_x", 64'(count_val()), 64'd1); step();
    idle(); read_chk("bub_m", 1, 5'd7, 32'h77, 1'b0);
    check_val("bub_count_m", 64'(count_val()), 64'd1); step();
    idle(); #1 check_val("bub_wb", 64'(wb_val), 64'd1); step();
    idle(); read_chk("bub_arch", 0, 5'd7, 32'h77, 1'b0);
    check_val("bub_count_end", 64'(count_val()), 64'd0); step();

    // async reset with three writers in flight
    idle(); issue(5'd10, 32'h10, 1'b0); step();
    idle(); issue(5'd11, 32'h11, 1'b0); produce(0, 32'h10); step();
    idle(); issue(5'd12, 32'h12, 1'b0); produce(0, 32'h11); step();
    idle(); produce(0, 32'h12); rd_addr[0] = 5'd12;
    #1;
    check_val("rst_mid_count", 64'(count_val()), 64'd3);
    check_val("rst_mid_wb_pre", 64'(wb_val), 64'd1);
    check_val("rst_mid_fwd_pre", 64'(rd_data[0]), 64'h12);
    reset = 1'b0;
    #1;
    check_val("rst_mid_wb", 64'(wb_val), 64'd0);
    check_val("rst_mid_data", 64'(rd_data[0]), 64'd0);
    check_val("rst_mid_stall", 64'(rd_stall), 64'd0);
    check_val("rst_mid_count0", 64'(count_val()), 64'd0);
    step();
    #2 reset = 1'b1;
    idle(); issue(5'd13, 32'h13, 1'b1); step();
    idle(); produce(0, 32'h13); read_chk("rst_first", 0, 5'd13, 32'h13, 1'b0); step();
    idle(); step();
    idle(); step();
    for (int r = 1; r < NR; r++) begin
      idle();
      read_chk("rst_sweep", r % 2, AW'(r), (r == 13) ? 32'h13 : 32'd0, 1'b0);
      step();
    end

    idle(); repeat (3) step();
    check_val("wb_q_empty", 64'(wb_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lab2_proc_fwd_regfile.md
# lab2_proc_fwd_regfile

Parametrised register file with a built-in in-flight destination tracker and forwarding network. It replaces the plain 2r1w register file and the hand-wired X/M/W result registers of the stalling pipeline. It tracks up to `p_nstages` in-flight writers (stage 0 = X, youngest), forwards their results to `p_nrd` D-stage read ports, and reports per-port stalls when a needed result is not yet produced. The oldest stage retires into the architectural array.

## Interface
Parameters:
- `p_nbits`, 32: data width.
- `p_nregs`, 32: architectural registers; `AW = $clog2(p_nregs)`.
- `p_nrd`, 2: read ports.
- `p_nstages`, 3: tracked in-flight stages (≥1).

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low; 0 clears all state immediately.
- `rd_addr`  in  p_nrd×AW: D-stage source addresses.
- `rd_data`  out  p_nrd×p_nbits: forwarded/array read data.
- `rd_stall`  out  p_nrd: port needs an unproduced result.
- `iss_val`, `iss_wen`  in  1 each: D-stage instruction issues; it writes rd.
- `iss_waddr`  in  AW: destination register.
- `stage_en`  in  p_nstages: per-stage advance enable (reg_en_X/M/W equivalents).
- `stage_squash`  in  p_nstages: kill entry at next edge.
- `produce_val`  in  p_nstages: stage s computes its result this cycle.
- `produce_data`  in  p_nstages×p_nbits: that result.
- `wb_val`  out  1: register write this cycle (oldest stage, wen, addr≠0).
- `wb_addr`  out  AW; `wb_data`  out  p_nbits: register write address and data.

## Operation
- Each entry holds {val, wen, waddr, data, rdy}. Entry "effective data" = `data` if rdy, else `produce_data[s]` if `produce_val[s]`, else unavailable.
- Read port p, addr a:
  - a==0 → data 0, no stall.
  - Otherwise scan s=0..p_nstages-1; first entry with val & wen & waddr==a wins.
    - Effective data available → forwarded.
    - Otherwise `rd_stall[p]`=1 and `rd_data[p]`=0.
  - No match → array[a].
- Advance, per edge:
  - Stage 0 with `stage_en[0]`: loads {iss_val, iss_wen, iss_waddr, rdy=0}.
  - Stage s>0 with `stage_en[s]`:
    - `stage_en[s-1]`=1 → takes entry s-1 with its effective data; rdy set if available.
    - `stage_en[s-1]`=0 → takes a bubble (val=0).
  - Stage not enabled: holds; captures `produce_data` and sets rdy if `produce_val`.
- Squash: `stage_squash[s]` forces entry s val=0 at the edge, overriding all loads.
- Retire: the oldest stage writes array[waddr] at the edge when val & wen & waddr≠0 & `stage_en[last]`, using its effective data.
  - The oldest stage valid with wen but no effective data is a protocol error; the bench asserts it never occurs.
- Register 0 is never written and always reads 0.
- Same-cycle retire and read of the same register: the tracker match supplies the new value. The array is never read stale.

## Timing
- Reads, forwarding and stall are combinational (same cycle as `rd_addr` / `produce_*`).
- Issue to architectural visibility: p_nstages edges with all enables high. Forwarding is available from the cycle the result is produced.
- Reset mid-operation: all entries val=0 and array cleared to 0 asynchronously. `wb_val`=0, `rd_stall`=0 and `rd_data`=0 while reset is low. The first issue is accepted on the first edge after release.
- Simultaneous squash and enable on the same stage: squash wins.

## Structure
- Shared package `lab2_proc_fwd_pkg`: entry struct typedef {val, wen, waddr, data, rdy} and `AW` helper function.
- Sub-module `lab2_proc_fwd_entry`: one tracker stage, covering load/hold/capture/squash. It is instantiated p_nstages times via generate.
- Array, priority match and retire logic stay in the top.

## Test plan
- Back-to-back dependency: issue x5←(X produces 7), next cycle read x5 → `rd_data`=7 forwarded from stage 0, no stall. After 3 edges, array[5]=7 and `wb_val` pulsed once.
- Load-use: issue x6 with `produce_val[0]`=0 and `produce_val[1]`=1/0x55 one cycle later; read x6 → `rd_stall`=1 for one cycle, then 0x55 forwarded.
- Priority: two in-flight writers of x3 (stage 1=0xA, stage 0=0xB) → read returns 0xB. Squash stage 0 → next cycle read returns 0xA.
- x0: issue write x0←0xFF, read x0 at every stage → 0, `wb_val` never asserts.
- Stall bubble: `stage_en`=3'b110 for one cycle → stage 0 holds, stage 1 gets bubble, no duplicate retire, entry counts are consistent.
- Async reset mid-flight: pull reset low between edges with 3 valid entries → `wb_val`=0 immediately; after release, every register reads 0.
